// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch bus between core_sequencer (master) and instruction memory (slave).
// The handshake is req/rdy: data is taken in any cycle where imem_req and imem_rdy are both 1.
interface core_sequencer_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rdy;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rdata
  );
endinterface

// File: rtl/core_sequencer.sv
// Four-stage FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the 8-bit mini CPU.
// Optional performance counters are enabled with `define CORE_SEQ_PERF_EN.
module core_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter logic [3:0]  HALT_OPC = 4'hF
`ifdef CORE_SEQ_PERF_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_load_val,
  core_sequencer_if.master   imem,
  output logic [INSTR_W-1:0] ir,
  output logic               dec_en,
  output logic               ex_en,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               halt_hit,
  output logic               retire
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_retired,
  output logic [CNT_W-1:0]   perf_stall
`endif
);

  typedef enum logic [2:0] {
    StHalted,
    StFetch,
    StDecode,
    StExecute,
    StWriteback
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halt_hit_q, halt_hit_d;
  logic               step_mode_q, step_mode_d;
  logic [3:0]         opcode;
  logic               writes_rf;

  assign opcode    = ir_q[INSTR_W-1 -: 4];
  assign writes_rf = (opcode >= 4'd1) && (opcode <= 4'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHalted;
      pc_q        <= '0;
      ir_q        <= '0;
      halt_hit_q  <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      halt_hit_q  <= halt_hit_d;
      step_mode_q <= step_mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    halt_hit_d  = halt_hit_q;
    step_mode_d = step_mode_q;
    case (state_q)
      StHalted: begin
        // pc_load wins over run/step so a host can reposition without starting.
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (run) begin
          state_d     = StFetch;
          step_mode_d = 1'b0;
          halt_hit_d  = 1'b0;
        end else if (step) begin
          state_d     = StFetch;
          step_mode_d = 1'b1;
          halt_hit_d  = 1'b0;
        end
      end
      StFetch: begin
        if (imem.imem_rdy) begin
          ir_d    = imem.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // HALT leaves pc on itself, so resuming refetches it until pc_load moves on.
        if (opcode == HALT_OPC) begin
          state_d    = StHalted;
          halt_hit_d = 1'b1;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        state_d = StWriteback;
      end
      StWriteback: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = (step_mode_q || !run) ? StHalted : StFetch;
      end
      default: begin
        state_d = StHalted;
      end
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    dec_en        = 1'b0;
    ex_en         = 1'b0;
    rf_we         = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state_q)
      StHalted:    halted        = 1'b1;
      StFetch:     imem.imem_req = 1'b1;
      StDecode:    dec_en        = 1'b1;
      StExecute:   ex_en         = 1'b1;
      StWriteback: begin
        retire = 1'b1;
        rf_we  = writes_rf;
      end
      default:     halted        = 1'b0;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign ir             = ir_q;
  assign halt_hit       = halt_hit_q;

`ifdef CORE_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_retired_q, perf_stall_q;

  // Both counters stick at all-ones and only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (retire && (perf_retired_q != '1)) begin
        perf_retired_q <= perf_retired_q + CNT_W'(1);
      end
      if ((state_q == StFetch) && !imem.imem_rdy && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + CNT_W'(1);
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

  // Stage enables are mutually exclusive and a write only happens on a retiring instruction.
  a_stage_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({imem.imem_req, dec_en, ex_en, retire, halted}));
  a_we_retire: assert property (@(posedge clk) disable iff (rst) rf_we |-> retire);

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction-level reference model plus directed scenarios.
module tb_core_sequencer;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               run = 1'b0;
  logic               step = 1'b0;
  logic               pc_load = 1'b0;
  logic [PC_W-1:0]    pc_load_val = '0;
  logic               rdy = 1'b1;
  logic [INSTR_W-1:0] ir;
  logic               dec_en, ex_en, rf_we, halted, halt_hit, retire;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] mem [256];
`ifdef CORE_SEQ_PERF_EN
  logic [15:0]        perf_retired, perf_stall;
`endif

  core_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem_bus ();

  assign imem_bus.imem_rdy   = rdy;
  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];

  core_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .imem        (imem_bus.master),
    .ir          (ir),
    .dec_en      (dec_en),
    .ex_en       (ex_en),
    .rf_we       (rf_we),
    .pc          (pc),
    .halted      (halted),
    .halt_hit    (halt_hit),
    .retire      (retire)
`ifdef CORE_SEQ_PERF_EN
    ,
    .perf_retired(perf_retired),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: an instruction is a fetch wait followed by the decode,
  // execute and writeback beats counted from fetch acceptance.
  bit              m_busy;
  int              m_beat;
  bit              m_step;
  bit              m_hh;
  logic [PC_W-1:0] m_pc;
  logic [15:0]     m_ir;
  int              m_ret, m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_beat <= 0; m_step <= 1'b0; m_hh <= 1'b0;
      m_pc <= '0; m_ir <= '0; m_ret <= 0; m_stall <= 0;
    end else if (!m_busy) begin
      if (pc_load) m_pc <= pc_load_val;
      else if (run || step) begin
        m_busy <= 1'b1; m_beat <= 0; m_step <= !run; m_hh <= 1'b0;
      end
    end else if (m_beat == 0) begin
      if (rdy) begin m_ir <= mem[m_pc]; m_beat <= 1; end
      else m_stall <= m_stall + 1;
    end else if (m_beat == 1) begin
      if (m_ir[15:12] == 4'hF) begin m_busy <= 1'b0; m_hh <= 1'b1; end
      else m_beat <= 2;
    end else if (m_beat == 2) begin
      m_beat <= 3;
    end else begin
      m_pc  <= m_pc + 8'd1;
      m_ret <= m_ret + 1;
      if (m_step || !run) m_busy <= 1'b0;
      else m_beat <= 0;
    end
  end

  int cyc = 0;
  int rfwe_cnt = 0;
  int req_cnt = 0;
  int ret_cycles[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("halted", halted, !m_busy);
      chk("imem_req", imem_bus.imem_req, m_busy && m_beat == 0);
      chk("dec_en", dec_en, m_busy && m_beat == 1);
      chk("ex_en", ex_en, m_busy && m_beat == 2);
      chk("retire", retire, m_busy && m_beat == 3);
      chk("rf_we", rf_we, m_busy && m_beat == 3 && m_ir[15:12] >= 4'd1 && m_ir[15:12] <= 4'd4);
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_bus.imem_addr, m_pc);
      chk("ir", ir, m_ir);
      chk("halt_hit", halt_hit, m_hh);
`ifdef CORE_SEQ_PERF_EN
      chk("perf_retired", perf_retired, m_ret);
      chk("perf_stall", perf_stall, m_stall);
`endif
      if (retire) ret_cycles.push_back(cyc);
      if (rf_we) rfwe_cnt++;
      if (imem_bus.imem_req) req_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int t0, rfwe0, req0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1123;
    mem[1] = 16'h2455;
    mem[2] = 16'hF000;

    tick(2);
    chk("rst_halted", halted, 1);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_halt_hit", halt_hit, 0);
    chk("rst_req", imem_bus.imem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_rf_we", rf_we, 0);
    rst = 1'b0;
    tick(2);

    // Free-run a two-instruction program ending in HALT.
    ret_cycles.delete(); t0 = cyc; run = 1'b1;
    tick(10);
    run = 1'b0;
    tick(2);
    chk("t1_retires", ret_cycles.size(), 2);
    chk("t1_ret0_cycle", ret_cycles[0] - t0, 4);
    chk("t1_ret1_cycle", ret_cycles[1] - t0, 8);
    chk("t1_rf_we_cnt", rfwe_cnt, 2);
    chk("t1_halted", halted, 1);
    chk("t1_halt_hit", halt_hit, 1);
    chk("t1_pc", pc, 2);

    // Stepping from a HALT refetches the same HALT.
    step = 1'b1; tick(1); step = 1'b0;
    tick(4);
    chk("refetch_halted", halted, 1);
    chk("refetch_halt_hit", halt_hit, 1);
    chk("refetch_pc", pc, 2);

    // pc_load beats step in the same cycle.
    pc_load_val = 8'h00; pc_load = 1'b1; step = 1'b1;
    tick(1);
    pc_load = 1'b0; step = 1'b0;
    chk("load_prio_halted", halted, 1);
    chk("load_prio_pc", pc, 0);

    // Single step from pc=0.
    ret_cycles.delete(); t0 = cyc; step = 1'b1; tick(1); step = 1'b0;
    tick(5);
    chk("t2_retires", ret_cycles.size(), 1);
    chk("t2_ret_cycle", ret_cycles[0] - t0, 4);
    chk("t2_halted", halted, 1);
    chk("t2_pc", pc, 1);
    chk("t2_halt_hit", halt_hit, 0);

    // Three fetch wait cycles; a step pulse mid-instruction must not queue.
    rdy = 1'b0; ret_cycles.delete(); t0 = cyc; step = 1'b1; tick(1); step = 1'b0;
    tick(2);
    chk("t3_req_held", imem_bus.imem_req, 1);
    chk("t3_pc_held", pc, 1);
    chk("t3_ir_held", ir, 16'h1123);
    tick(1); rdy = 1'b1;
    tick(1); step = 1'b1; tick(1); step = 1'b0;
    tick(3);
    chk("t3_retires", ret_cycles.size(), 1);
    chk("t3_ret_cycle", ret_cycles[0] - t0, 7);
    chk("t3_halted", halted, 1);
    chk("t3_pc", pc, 2);
`ifdef CORE_SEQ_PERF_EN
    chk("t3_perf_stall", perf_stall, 3);
`endif

    // NOP at 8'hFF wraps pc without a register write.
    pc_load_val = 8'hFF; pc_load = 1'b1; tick(1); pc_load = 1'b0;
    chk("t4_pc_loaded", pc, 8'hFF);
    rfwe0 = rfwe_cnt; ret_cycles.delete();
    step = 1'b1; tick(1); step = 1'b0;
    tick(5);
    chk("t4_no_rf_we", rfwe_cnt - rfwe0, 0);
    chk("t4_retires", ret_cycles.size(), 1);
    chk("t4_pc_wrap", pc, 0);
    chk("t4_halted", halted, 1);

    // run dropped in EXECUTE: the ADD still writes back, then stop.
    rfwe0 = rfwe_cnt; req0 = req_cnt; run = 1'b1;
    tick(3);
    chk("t5_in_execute", ex_en, 1);
    run = 1'b0;
    tick(4);
    chk("t5_rf_we", rfwe_cnt - rfwe0, 1);
    chk("t5_one_fetch", req_cnt - req0, 1);
    chk("t5_halted", halted, 1);
    chk("t5_pc", pc, 1);
`ifdef CORE_SEQ_PERF_EN
    chk("t5_perf_retired", perf_retired, 6);
`endif

    // Asynchronous reset in EXECUTE aborts before any write.
    rfwe0 = rfwe_cnt; run = 1'b1;
    tick(3);
    chk("t6_in_execute", ex_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_halted", halted, 1);
    chk("t6_async_pc", pc, 0);
    chk("t6_async_ex_en", ex_en, 0);
    chk("t6_async_rf_we", rf_we, 0);
    chk("t6_async_ir", ir, 0);
    run = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("t6_no_rf_we", rfwe_cnt - rfwe0, 0);
    chk("t6_halted", halted, 1);
`ifdef CORE_SEQ_PERF_EN
    chk("t6_perf_cleared", perf_retired, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
